delay_pipe: RTL and testbench

Parametrised elastic delay line: WIDTH-bit data with valid/ready handshake through DEPTH register stages. It supersedes the fixed single-stage 8-bit valid/data delay register. It adds configurable width and depth, downstream backpressure with bubble collapsing, flush, and an occupancy count. It sits between HLS-generated cores and fabric logic wherever a fixed latency must be matched or a timing path broken without losing data under stall.

---
 rtl/delay_pipe.sv | 110 +++++++++++
 tb/tb_delay_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_pipe.sv
// delay_pipe: elastic valid/ready delay line of DEPTH register stages.
// An empty stage always loads from upstream, so bubbles collapse while
// the output is stalled. count_o tracks how many stages hold valid data.
// Optional macro DELAY_PIPE_DATA_RESET_EN: reset and flush also clear the
// data registers. When it is undefined, the data registers have no reset.
module delay_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]               count_q, count_d;
  logic [DEPTH:0]              en;
  logic [DEPTH-1:0]            src_v;
  logic [DEPTH-1:0][WIDTH-1:0] src_d;

  // Stage enables: a stage may advance if it, or any stage below it, is empty, or the sink is ready
  always_comb begin
    logic acc;
    acc       = ready_i;
    en        = '0;
    en[DEPTH] = ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc   = acc | ~v_q[k];
      en[k] = acc;
    end
  end

  // Source of each stage: upstream input for stage 0, the previous stage otherwise
  always_comb begin
    src_v    = '0;
    src_d    = '0;
    src_v[0] = valid_i;
    src_d[0] = data_i;
    for (int k = 1; k < DEPTH; k++) begin
      src_v[k] = v_q[k-1];
      src_d[k] = d_q[k-1];
    end
  end

  // Next-state for valid bits and data; data only moves when the source holds a valid word
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
`ifdef DELAY_PIPE_DATA_RESET_EN
      d_d = '0;
`endif
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (en[k]) begin
          v_d[k] = src_v[k];
          if (src_v[k]) d_d[k] = src_d[k];
        end
      end
    end
  end

  // Occupancy for the next cycle, so count_o stays a registered popcount of the valid bits
  always_comb begin
    count_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_d = count_d + CW'(v_d[k]);
    end
  end

  // Valid bits and occupancy; reset takes priority over flush
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= '0;
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
    end
  end

`ifdef DELAY_PIPE_DATA_RESET_EN
  // Data registers, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) d_q <= '0;
    else       d_q <= d_d;
  end
`else
  // Data registers, deliberately without reset; only the valid bits qualify them
  always_ff @(posedge clk) begin
    d_q <= d_d;
  end
`endif

  assign ready_o = en[0];
  assign valid_o = v_q[DEPTH-1];
  assign data_o  = d_q[DEPTH-1];
  assign count_o = count_q;

endmodule

// File: tb/tb_delay_pipe.sv
// tb_delay_pipe: randomized and directed check of delay_pipe against a
// behavioural model. The model is a FIFO of words tagged with their accept
// cycle. A word may be at the output once DEPTH-1 edges have passed since
// it was accepted and every older word has left. A second DEPTH=1 instance,
// with ready_i tied high, is compared against a plain one-cycle delay.
module tb_delay_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset, flush, valid_i, ready_i;
  logic [WIDTH-1:0] data_i;
  logic             ready_o, valid_o;
  logic [WIDTH-1:0] data_o;
  logic [CW-1:0]    count_o;
  logic             ready1_o, valid1_o;
  logic [WIDTH-1:0] data1_o;
  logic [0:0]       count1_o;

  always #5 clk = ~clk;

  delay_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .count_o(count_o)
  );

  delay_pipe #(.WIDTH(WIDTH), .DEPTH(1)) u_leg (
    .clk(clk), .reset(reset), .flush(1'b0),
    .valid_i(valid_i), .ready_o(ready1_o), .data_i(data_i),
    .valid_o(valid1_o), .ready_i(1'b1), .data_o(data1_o), .count_o(count1_o)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    int               a;
  } ent_t;

  ent_t             q[$];
  int               cyc;
  bit               model_ok = 1'b0;
  logic             m1_v;
  logic [WIDTH-1:0] m1_d;
  int               checks   = 0;
  int               failures = 0;
  logic [8:0]       got[$];
  int               nvalid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic head_visible();
    return (q.size() > 0) && (cyc >= q[0].a + DEPTH - 1);
  endfunction

  // Per-cycle comparison of both instances against the model, before the edge
  task automatic compare();
    logic ev;
    ev = head_visible();
    chk("valid_o", valid_o, ev);
    if (ev) chk("data_o", data_o, q[0].d);
    chk("count_o", count_o, q.size());
    chk("ready_o", ready_o, (ready_i || q.size() < DEPTH));
    chk("leg_valid", valid1_o, m1_v);
    if (m1_v) chk("leg_data", data1_o, m1_d);
    chk("leg_count", count1_o, m1_v);
    chk("leg_ready", ready1_o, 1);
  endtask

  // Model update at the rising edge, using the inputs held across it
  task automatic update();
    logic ev, er;
    ev = head_visible();
    er = ready_i || (q.size() < DEPTH);
    cyc++;
    if (reset || flush) begin
      q.delete();
    end else begin
      if (ev && ready_i) void'(q.pop_front());
      if (valid_i && er) q.push_back('{data_i, cyc});
    end
    if (reset) m1_v = 1'b0;
    else begin
      m1_v = valid_i;
      if (valid_i) m1_d = data_i;
    end
  endtask

  task automatic tick();
    #1;
    if (model_ok) compare();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic collect(input int n);
    got.delete();
    for (int t = 0; t < n; t++) begin
      got.push_back({valid_o, data_o});
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b1; data_i = '0;
    cyc = 0; m1_v = 1'b0; m1_d = '0;
    @(negedge clk);
    @(posedge clk);
    q.delete();
    model_ok = 1'b1;
    @(negedge clk);
    tick();
    chk("rst_valid", valid_o, 0);
    chk("rst_count", count_o, 0);
    #1 chk("rst_ready", ready_o, 1);
`ifdef DELAY_PIPE_DATA_RESET_EN
    chk("rst_data", data_o, 8'h00);
`endif
    reset = 1'b0;

    // Streaming 0x01..0x10 with ready_i high
    ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      valid_i = (i < 16);
      data_i  = 8'(i + 1);
      #1 chk("stream_ready", ready_o, 1);
      tick();
      if (i == 2)  chk("stream_lat_lo", valid_o, 0);
      if (i == 3)  chk("stream_first", {valid_o, data_o}, 9'h101);
      if (i == 10) chk("stream_count", count_o, 4);
      if (i == 18) chk("stream_last", {valid_o, data_o}, 9'h110);
      if (i == 19) chk("stream_end", valid_o, 0);
    end

    // Backpressure fill: only four words fit
    ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      valid_i = 1'b1;
      data_i  = 8'hA0 + 8'(k);
      #1 chk("fill_ready", ready_o, (k < 4));
      tick();
    end
    chk("fill_count", count_o, 4);
    valid_i = 1'b0;
    #1 chk("fill_ready_lo", ready_o, 0);
    ready_i = 1'b1;
    collect(6);
    chk("fill_out0", got[0], 9'h1A0);
    chk("fill_out1", got[1], 9'h1A1);
    chk("fill_out2", got[2], 9'h1A2);
    chk("fill_out3", got[3], 9'h1A3);
    chk("fill_out4", got[4][8], 0);

    // Bubble collapse: two-cycle gap between 0x11 and 0x22 under stall
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 8'h11; tick();
    valid_i = 1'b0; tick(); tick();
    valid_i = 1'b1; data_i = 8'h22; tick();
    valid_i = 1'b0; tick(); tick(); tick();
    chk("bubble_count", count_o, 2);
    ready_i = 1'b1;
    collect(4);
    chk("bubble_out0", got[0], 9'h111);
    chk("bubble_out1", got[1], 9'h122);
    chk("bubble_out2", got[2][8], 0);

    // Simultaneous in/out while full
    ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid_i = 1'b1; data_i = 8'hB0 + 8'(k); tick();
    end
    ready_i = 1'b1; valid_i = 1'b1; data_i = 8'h55;
    #1 chk("full_ready", ready_o, 1);
    chk("full_head", {valid_o, data_o}, 9'h1B0);
    tick();
    chk("full_count", count_o, 4);
    chk("full_next", {valid_o, data_o}, 9'h1B1);
    valid_i = 1'b0;
    collect(5);
    chk("full_out0", got[0], 9'h1B1);
    chk("full_out1", got[1], 9'h1B2);
    chk("full_out2", got[2], 9'h1B3);
    chk("full_out3", got[3], 9'h155);

    // Flush mid-stream drops contents and the word offered with it
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid_i = 1'b1; data_i = 8'hC0 + 8'(k); tick();
    end
    flush = 1'b1; valid_i = 1'b1; data_i = 8'h77; tick();
    flush = 1'b0; valid_i = 1'b0;
    chk("flush_count", count_o, 0);
    chk("flush_valid", valid_o, 0);
    #1 chk("flush_ready", ready_o, 1);
    ready_i = 1'b1;
    nvalid = 0;
    for (int t = 0; t < 6; t++) begin
      if (valid_o) nvalid++;
      tick();
    end
    chk("flush_no_out", nvalid, 0);

    // Reset mid-stream
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid_i = 1'b1; data_i = 8'hD0 + 8'(k); tick();
    end
    reset = 1'b1; valid_i = 1'b1; data_i = 8'h77; tick();
    reset = 1'b0; valid_i = 1'b0;
    chk("rstm_count", count_o, 0);
    chk("rstm_valid", valid_o, 0);
`ifdef DELAY_PIPE_DATA_RESET_EN
    chk("rstm_data", data_o, 8'h00);
`endif
    #1 chk("rstm_ready", ready_o, 1);
    ready_i = 1'b1;
    nvalid = 0;
    for (int t = 0; t < 6; t++) begin
      if (valid_o) nvalid++;
      tick();
    end
    chk("rstm_no_out", nvalid, 0);

    // Legacy single-stage behaviour on the DEPTH=1 instance
    valid_i = 1'b1; data_i = 8'h3C; tick();
    chk("leg_3c", {valid1_o, data1_o}, 9'h13C);
    valid_i = 1'b1; data_i = 8'hC3; tick();
    chk("leg_c3", {valid1_o, data1_o}, 9'h1C3);
    valid_i = 1'b0; tick();
    chk("leg_idle", valid1_o, 0);

    // Randomized traffic with phases of light and heavy backpressure
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 299) == 0);
      flush   = ($urandom_range(0, 149) == 0);
      valid_i = ($urandom_range(0, 3) != 0);
      data_i  = 8'($urandom);
      if ((i / 250) % 2 == 0) ready_i = ($urandom_range(0, 3) != 0);
      else                    ready_i = ($urandom_range(0, 3) == 0);
      tick();
    end
    reset = 1'b0; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
